// File: rtl/us_timming_slot_scheduler.sv
// ---------------------------------------------------------------------------
// us_timming_slot_scheduler
//
// Frame-level sequencer for the upstream timing-request driver. On each frame
// tick it walks cache slots 0..TOTAL_NUM-1. Slots whose bit is clear in the
// mask latched at frame start are skipped. For each enabled slot it:
// - issues a one-cycle start trigger carrying the slot number;
// - waits for the driver's done pulse, or for a timeout;
// - idles for a programmable gap.
// It owns the frame counter for the upstream path.
//
// Ports
//   sys_clk_i                 system clock
//   rst_i                     synchronous reset, active-high
//   enable_i                  permits starting new frames
//   frame_start_i             one-cycle frame tick
//   slot_mask_i               per-slot transmit enable, latched at frame start
//   gap_cycles_i              inter-slot idle cycles, latched at frame start
//   transmit_start_trigger_o  one-cycle start pulse to the driver
//   cache_num_o               slot number, held until the next trigger
//   frame_cnt_o               frame counter, changes only at end of frame
//   transmit_done_pluse_i     driver completion pulse
//   busy_o                    high while a frame is in progress
//   frame_done_pluse_o        one-cycle pulse at end of frame
//   timeout_cnt_o             saturating count of timed-out slots
//   overrun_cnt_o             saturating count of ticks dropped while busy
// ---------------------------------------------------------------------------
module us_timming_slot_scheduler #(
    parameter int TOTAL_NUM   = 104,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 sys_clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 frame_start_i,
    input  logic [TOTAL_NUM-1:0] slot_mask_i,
    input  logic [15:0]          gap_cycles_i,
    output logic                 transmit_start_trigger_o,
    output logic [7:0]           cache_num_o,
    output logic [15:0]          frame_cnt_o,
    input  logic                 transmit_done_pluse_i,
    output logic                 busy_o,
    output logic                 frame_done_pluse_o,
    output logic [15:0]          timeout_cnt_o,
    output logic [15:0]          overrun_cnt_o
);

    // The index must be able to reach TOTAL_NUM itself (end-of-scan marker).
    localparam int IDX_W   = $clog2(TOTAL_NUM + 1);
    localparam int TIMER_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SCAN = 3'd1,
        S_TRIG = 3'd2,
        S_WAIT = 3'd3,
        S_GAP  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [IDX_W-1:0]     idx_reg;
    logic [TIMER_W-1:0]   timer_reg;
    logic [15:0]          gap_cnt_reg;
    logic [TOTAL_NUM-1:0] mask_reg;
    logic [15:0]          gap_reg;
    logic [7:0]           cache_num_reg;
    logic [15:0]          frame_cnt_reg;
    logic [15:0]          timeout_cnt_reg;
    logic [15:0]          overrun_cnt_reg;

    // A zero is appended above the top slot so that indexing with
    // idx==TOTAL_NUM stays in range; that case is caught by scan_end first.
    logic [TOTAL_NUM:0]   mask_ext;
    logic                 scan_end;
    logic                 slot_en;
    logic                 timer_exp;
    logic                 gap_end;
    logic                 start_ok;

    assign mask_ext  = {1'b0, mask_reg};
    assign scan_end  = (idx_reg == IDX_W'(TOTAL_NUM));
    assign slot_en   = mask_ext[idx_reg];
    assign timer_exp = (timer_reg == TIMER_W'(TIMEOUT_CYC - 1));
    assign gap_end   = (gap_cnt_reg == 16'd0);
    assign start_ok  = frame_start_i && enable_i;

    // State register
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (start_ok) state_next = S_SCAN;
            S_SCAN: begin
                if (scan_end) begin
                    state_next = S_DONE;
                end else if (slot_en) begin
                    state_next = S_TRIG;
                end
            end
            S_TRIG: state_next = S_WAIT;
            S_WAIT: if (transmit_done_pluse_i || timer_exp) state_next = S_GAP;
            S_GAP:  if (gap_end) state_next = S_SCAN;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Strobes are decoded from the state register only, so no input reaches
    // these outputs combinationally.
    always_comb begin
        transmit_start_trigger_o = (state_reg == S_TRIG);
        busy_o                   = (state_reg != S_IDLE);
        frame_done_pluse_o       = (state_reg == S_DONE);
    end

    // Datapath
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            idx_reg         <= '0;
            timer_reg       <= '0;
            gap_cnt_reg     <= '0;
            mask_reg        <= '0;
            gap_reg         <= '0;
            cache_num_reg   <= '0;
            frame_cnt_reg   <= '0;
            timeout_cnt_reg <= '0;
            overrun_cnt_reg <= '0;
        end else begin
            // A tick while busy is dropped and only counted.
            if (frame_start_i && (state_reg != S_IDLE) && (overrun_cnt_reg != 16'hFFFF)) begin
                overrun_cnt_reg <= overrun_cnt_reg + 16'd1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (start_ok) begin
                        mask_reg <= slot_mask_i;
                        gap_reg  <= gap_cycles_i;
                        idx_reg  <= '0;
                    end
                end
                S_SCAN: begin
                    if (!scan_end) begin
                        if (slot_en) begin
                            // Loaded on entry to S_TRIG so the number is valid
                            // together with the trigger and held afterwards.
                            cache_num_reg <= 8'(idx_reg);
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end
                end
                S_TRIG: begin
                    timer_reg <= '0;
                end
                S_WAIT: begin
                    if (transmit_done_pluse_i) begin
                        timer_reg   <= '0;
                        gap_cnt_reg <= gap_reg;
                    end else if (timer_exp) begin
                        timer_reg   <= '0;
                        gap_cnt_reg <= gap_reg;
                        if (timeout_cnt_reg != 16'hFFFF) begin
                            timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
                        end
                    end else begin
                        timer_reg <= timer_reg + TIMER_W'(1);
                    end
                end
                S_GAP: begin
                    // The gap counter counts down from gap, giving gap+1 cycles.
                    if (gap_end) begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 16'd1;
                    end
                end
                S_DONE: begin
                    frame_cnt_reg <= frame_cnt_reg + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign cache_num_o   = cache_num_reg;
    assign frame_cnt_o   = frame_cnt_reg;
    assign timeout_cnt_o = timeout_cnt_reg;
    assign overrun_cnt_o = overrun_cnt_reg;

endmodule
